poci_master_arbiter: RTL and testbench

//  Shares one POCI (APB) bus between NUM_MASTERS upstream POCI masters, e.g. the HASTI bridge and a DMA engine.

---
 rtl/poci_pkg.sv | 22 ++
 rtl/poci_rr_picker.sv | 28 ++
 rtl/poci_master_arbiter.sv | 145 ++++++++++++++
 tb/tb_poci_master_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poci_pkg.sv
// Shared types and helpers for the POCI master arbiter.
package poci_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } poci_state_e;

  localparam int unsigned MAX_MASTERS = 4;

  // Index width for n items, never less than 1 bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/poci_rr_picker.sv
// Combinational round-robin first-one search over a request vector, starting at ptr_i.
module poci_rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int unsigned j;

  // Walk offsets from highest to lowest so the nearest request to ptr_i wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      j = (32'(ptr_i) + 32'(k)) % N;
      if (req_i[IW'(j)]) begin
        idx_o   = IW'(j);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/poci_master_arbiter.sv
// Round-robin arbiter sharing one POCI (APB) bus between several masters.
// Optional ACCESS watchdog enabled by defining POCI_TIMEOUT_EN.
module poci_master_arbiter
  import poci_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_paddr,
  input  logic [NUM_MASTERS-1:0]        m_pwrite,
  input  logic [NUM_MASTERS-1:0]        m_psel,
  input  logic [NUM_MASTERS-1:0]        m_penable,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_pwdata,
  output logic [DATA_W-1:0]             m_prdata,
  output logic [NUM_MASTERS-1:0]        m_pready,
  output logic                          m_pslverr,
  output logic [ADDR_W-1:0]             s_paddr,
  output logic                          s_pwrite,
  output logic                          s_psel,
  output logic                          s_penable,
  output logic [DATA_W-1:0]             s_pwdata,
  input  logic [DATA_W-1:0]             s_prdata,
  input  logic                          s_pready,
  input  logic                          s_pslverr
);

  localparam int unsigned IW = clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_param_check
    $error("NUM_MASTERS must be between 2 and MAX_MASTERS");
  end

  poci_state_e     state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            psel_q, penable_q;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic            busy;
  logic            done;
  logic            timeout;

  logic [ADDR_W-1:0] paddr_arr [NUM_MASTERS];
  logic [DATA_W-1:0] pwdata_arr [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign paddr_arr[i]  = m_paddr[i*ADDR_W +: ADDR_W];
    assign pwdata_arr[i] = m_pwdata[i*DATA_W +: DATA_W];
  end

  // Masters' penable is implied by the sequencer; it carries no extra information here.
  logic unused_inputs;
  assign unused_inputs = ^{m_penable, TIMEOUT_CYCLES};

  poci_rr_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_picker (
    .req_i   (m_psel),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

`ifdef POCI_TIMEOUT_EN
  localparam int unsigned TW = clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout = (state_q == StAccess) && !s_pready &&
                   (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != StAccess) tmo_cnt_d = '0;
    else if (!s_pready)      tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign busy = (state_q != StIdle);
  assign done = (state_q == StAccess) && (s_pready || timeout);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = StSetup;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (done) begin
          ptr_d   = (grant_q == IW'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ptr_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      psel_q    <= (state_d != StIdle);
      penable_q <= (state_d == StAccess);
    end
  end

  assign s_psel    = psel_q;
  assign s_penable = penable_q;
  assign s_paddr   = busy ? paddr_arr[grant_q] : '0;
  assign s_pwdata  = busy ? pwdata_arr[grant_q] : '0;
  assign s_pwrite  = busy ? m_pwrite[grant_q] : 1'b0;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_ready
    assign m_pready[i] = done && (grant_q == IW'(i));
  end

  // A watchdog completion returns no data, only the error flag.
  assign m_prdata  = (done && !timeout) ? s_prdata : '0;
  assign m_pslverr = done && (timeout || s_pslverr);

endmodule

// File: tb/tb_poci_master_arbiter.sv
// Self-checking bench for poci_master_arbiter: directed scenarios plus randomized traffic.
module tb_poci_master_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk, reset;
  logic [N*AW-1:0] m_paddr;
  logic [N-1:0]    m_pwrite, m_psel, m_penable;
  logic [N*DW-1:0] m_pwdata;
  logic [DW-1:0]   m_prdata;
  logic [N-1:0]    m_pready;
  logic            m_pslverr;
  logic [AW-1:0]   s_paddr;
  logic            s_pwrite, s_psel, s_penable;
  logic [DW-1:0]   s_pwdata, s_prdata;
  logic            s_pready, s_pslverr;

  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] data_a [N];

  int checks, errors;
  int ms, mg, mp, mc;  // model: phase (0 idle, 1 setup, 2 access), owner, rr pointer, wait count

  logic [AW-1:0] smp_paddr;
  logic [DW-1:0] smp_pwdata, smp_prdata;
  logic          smp_psel, smp_penable, smp_pwrite, smp_pslverr;
  logic [N-1:0]  smp_pready;

  poci_master_arbiter #(
    .NUM_MASTERS    (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m_paddr   (m_paddr),
    .m_pwrite  (m_pwrite),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pwdata  (m_pwdata),
    .m_prdata  (m_prdata),
    .m_pready  (m_pready),
    .m_pslverr (m_pslverr),
    .s_paddr   (s_paddr),
    .s_pwrite  (s_pwrite),
    .s_psel    (s_psel),
    .s_penable (s_penable),
    .s_pwdata  (s_pwdata),
    .s_prdata  (s_prdata),
    .s_pready  (s_pready),
    .s_pslverr (s_pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_paddr[i*AW +: AW]  = addr_a[i];
      m_pwdata[i*DW +: DW] = data_a[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_m(input int i, input logic sel, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_psel[i]    = sel;
    m_penable[i] = sel;
    m_pwrite[i]  = wr;
    addr_a[i]    = a;
    data_a[i]    = d;
  endtask

  // One clock cycle: sample at negedge, compare against the model, advance the model,
  // then return 1 time unit after the next posedge so the caller can drive inputs.
  task automatic step();
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    logic [N-1:0]  e_rdy;
    logic          e_wr, e_psel, e_pen, e_err, done, tmo, found;
    @(negedge clk);
    smp_psel    = s_psel;
    smp_penable = s_penable;
    smp_paddr   = s_paddr;
    smp_pwrite  = s_pwrite;
    smp_pwdata  = s_pwdata;
    smp_pready  = m_pready;
    smp_prdata  = m_prdata;
    smp_pslverr = m_pslverr;
    if (reset) begin
      ms = 0; mg = 0; mp = 0; mc = 0;
    end
    tmo = 1'b0;
`ifdef POCI_TIMEOUT_EN
    tmo = (ms == 2) && !s_pready && (mc == TO - 1);
`endif
    done    = (ms == 2) && (s_pready || tmo);
    e_psel  = (ms != 0);
    e_pen   = (ms == 2);
    e_addr  = e_psel ? addr_a[mg] : '0;
    e_wdata = e_psel ? data_a[mg] : '0;
    e_wr    = e_psel ? m_pwrite[mg] : 1'b0;
    e_rdy   = '0;
    if (done) e_rdy[mg] = 1'b1;
    e_rdata = (done && !tmo) ? s_prdata : '0;
    e_err   = done && (tmo || s_pslverr);
    chk("psel", smp_psel, e_psel);
    chk("penable", smp_penable, e_pen);
    chk("paddr", smp_paddr, e_addr);
    chk("pwrite", smp_pwrite, e_wr);
    chk("pwdata", smp_pwdata, e_wdata);
    chk("m_pready", smp_pready, e_rdy);
    chk("m_prdata", smp_prdata, e_rdata);
    chk("m_pslverr", smp_pslverr, e_err);
    if (!reset) begin
      if (ms == 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && m_psel[(mp + k) % N]) begin
            mg = (mp + k) % N;
            found = 1'b1;
          end
        end
        if (found) ms = 1;
      end else if (ms == 1) begin
        ms = 2;
        mc = 0;
      end else if (done) begin
        mp = (mg + 1) % N;
        ms = 0;
      end else begin
        mc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] act;

  initial begin
    checks = 0; errors = 0;
    ms = 0; mg = 0; mp = 0; mc = 0;
    reset = 1'b1;
    m_psel = '0; m_penable = '0; m_pwrite = '0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = '0;
      data_a[i] = '0;
    end
    s_prdata = '0; s_pready = 1'b0; s_pslverr = 1'b0;
    step();
    step();
    chk("reset_psel", smp_psel, 1'b0);
    chk("reset_penable", smp_penable, 1'b0);
    chk("reset_pready", smp_pready, 2'b00);
    chk("reset_prdata", smp_prdata, 32'h0);
    reset = 1'b0;

    // Single zero-wait read from master 0.
    set_m(0, 1'b1, 1'b0, 32'hF000_0010, 32'h0);
    s_prdata = 32'hCAFE_F00D; s_pready = 1'b1;
    step();
    chk("rd_n_psel", smp_psel, 1'b0);
    step();
    chk("rd_n1_psel", smp_psel, 1'b1);
    chk("rd_n1_penable", smp_penable, 1'b0);
    chk("rd_n1_paddr", smp_paddr, 32'hF000_0010);
    step();
    chk("rd_n2_penable", smp_penable, 1'b1);
    chk("rd_n2_pready", smp_pready, 2'b01);
    chk("rd_n2_prdata", smp_prdata, 32'hCAFE_F00D);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("rd_n3_psel", smp_psel, 1'b0);

    // Contention with ptr back at 0: grants alternate 0,1,0,1.
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_m(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h0000_2000, 32'h0);
    for (int c = 0; c < 12; c++) begin
      step();
      chk("rr_pready", smp_pready,
          (c % 3 == 2) ? (((c / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00);
    end
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Write with three wait states ending in a slave error.
    set_m(0, 1'b1, 1'b1, 32'hF100_0004, 32'h1234_5678);
    s_pready = 1'b0;
    step();
    step();
    chk("ws_setup_pwdata", smp_pwdata, 32'h1234_5678);
    chk("ws_setup_pwrite", smp_pwrite, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ws_wait_pwdata", smp_pwdata, 32'h1234_5678);
      chk("ws_wait_pready", smp_pready, 2'b00);
    end
    s_pready = 1'b1; s_pslverr = 1'b1;
    step();
    chk("ws_done_pready", smp_pready, 2'b01);
    chk("ws_done_pslverr", smp_pslverr, 1'b1);
    chk("ws_done_pwdata", smp_pwdata, 32'h1234_5678);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_pready = 1'b0; s_pslverr = 1'b0;
    step();

    // Master 1 requests while master 0 is mid-ACCESS.
    set_m(0, 1'b1, 1'b0, 32'hA000_0000, 32'h0);
    step();
    step();
    step();
    set_m(1, 1'b1, 1'b0, 32'hB000_0008, 32'h0);
    step();
    chk("late_hold_pready", smp_pready, 2'b00);
    chk("late_hold_paddr", smp_paddr, 32'hA000_0000);
    s_pready = 1'b1; s_prdata = 32'h1111_2222;
    step();
    chk("late_m0_pready", smp_pready, 2'b01);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_pready = 1'b0;
    step();
    chk("late_idle_psel", smp_psel, 1'b0);
    step();
    chk("late_m1_psel", smp_psel, 1'b1);
    chk("late_m1_paddr", smp_paddr, 32'hB000_0008);
    s_pready = 1'b1;
    step();
    chk("late_m1_pready", smp_pready, 2'b10);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    s_pready = 1'b0;
    step();

`ifdef POCI_TIMEOUT_EN
    // Slave never answers: watchdog completes in the 8th ACCESS cycle.
    set_m(0, 1'b1, 1'b0, 32'hC000_0000, 32'h0);
    s_prdata = 32'hDEAD_BEEF;
    step();
    step();
    for (int k = 0; k < TO - 1; k++) begin
      step();
      chk("tmo_wait_pready", smp_pready, 2'b00);
    end
    step();
    chk("tmo_pready", smp_pready, 2'b01);
    chk("tmo_pslverr", smp_pslverr, 1'b1);
    chk("tmo_prdata", smp_prdata, 32'h0);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("tmo_idle_psel", smp_psel, 1'b0);
`endif

    // Reset asserted during ACCESS aborts the transfer at once.
    set_m(0, 1'b1, 1'b0, 32'hD000_0000, 32'h0);
    s_pready = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    chk("rst_mid_psel", smp_psel, 1'b0);
    chk("rst_mid_penable", smp_penable, 1'b0);
    chk("rst_mid_pready", smp_pready, 2'b00);
    reset = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("rst_after_psel", smp_psel, 1'b0);

    // Randomized traffic against the model.
    act = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (smp_pready[i]) begin
          act[i] = 1'b0;
          set_m(i, 1'b0, 1'b0, 32'h0, 32'h0);
        end
      end
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        act   = '0;
        for (int i = 0; i < N; i++) set_m(i, 1'b0, 1'b0, 32'h0, 32'h0);
      end else begin
        for (int i = 0; i < N; i++) begin
          if (!act[i] && $urandom_range(0, 2) == 0) begin
            act[i] = 1'b1;
            set_m(i, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
          end
        end
      end
      s_pready  = ($urandom_range(0, 3) != 0);
      s_prdata  = $urandom;
      s_pslverr = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
